// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle MOVI/ADD/SUB/MOV plus
// iterative shift-add MULT and restoring DIV, one done pulse per op.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_zero,
  output logic             bad_op
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_MOVI = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               req_q, req_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               dz_q, dz_d;
  logic               bad_q, bad_d;

  logic               op_movi, op_mov, op_add;
  logic               op_sub, op_mult, div_run, div_by0;
  logic               last;
  logic               fin, fin_dz, fin_bad;
  logic [WIDTH-1:0]   fin_res, fin_hi;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign op_movi = (op_q == OP_MOVI);
  assign op_mov  = (op_q == OP_MOV);
  assign op_add  = (op_q == OP_ADD);
  assign op_sub  = (op_q == OP_SUB);
  assign op_mult = (op_q == OP_MULT);
  assign div_run = (op_q == OP_DIV) && (b_q != '0);
  assign div_by0 = (op_q == OP_DIV) && (b_q == '0);
  assign last    = (cnt_q == CW'(WIDTH - 1));

  // acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
    bad_d    = bad_q;
    fin      = 1'b0;
    fin_res  = '0;
    fin_hi   = '0;
    fin_dz   = 1'b0;
    fin_bad  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_q) begin
          unique case (1'b1)
            op_mult: begin
              state_d = S_MUL;
              acc_d   = {{WIDTH{1'b0}}, b_q};
              cnt_d   = '0;
            end
            div_run: begin
              state_d = S_DIV;
              acc_d   = {{WIDTH{1'b0}}, a_q};
              cnt_d   = '0;
            end
            div_by0: begin
              fin     = 1'b1;
              fin_res = '1;
              fin_hi  = a_q;
              fin_dz  = 1'b1;
            end
            op_movi: begin
              fin     = 1'b1;
              fin_res = b_q;
            end
            op_mov: begin
              fin     = 1'b1;
              fin_res = a_q;
            end
            op_add: begin
              fin     = 1'b1;
              fin_res = a_q + b_q;
            end
            op_sub: begin
              fin     = 1'b1;
              fin_res = a_q - b_q;
            end
            default: begin
              fin     = 1'b1;
              fin_bad = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          fin     = 1'b1;
          fin_res = mul_next[WIDTH-1:0];
          fin_hi  = mul_next[2*WIDTH-1:WIDTH];
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          fin     = 1'b1;
          fin_res = div_next[WIDTH-1:0];
          fin_hi  = div_next[2*WIDTH-1:WIDTH];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      done_d   = 1'b1;
      result_d = fin_res;
      hi_d     = fin_hi;
      zero_d   = (fin_res == '0);
      dz_d     = fin_dz;
      bad_d    = fin_bad;
    end
  end

  // a pending MULT/DIV request blocks new starts until it completes
  always_comb begin
    req_d = start && (state_q == S_IDLE) && (state_d == S_IDLE);
    op_d  = req_d ? alu_control : op_q;
    a_d   = req_d ? a : a_q;
    b_d   = req_d ? b : b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      req_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      req_q    <= req_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      done_q   <= done_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
      bad_q    <= bad_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign hi       = hi_q;
  assign zero     = zero_q;
  assign div_zero = dz_q;
  assign bad_op   = bad_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued at
// issue, popped and compared on every done pulse.
module tb_alu_exec_unit;
  localparam int W = 32;

  localparam logic [3:0] MOVI = 4'b0000;
  localparam logic [3:0] MOV  = 4'b0001;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] MULT = 4'b0011;
  localparam logic [3:0] DIV  = 4'b0100;
  localparam logic [3:0] SUB  = 4'b0110;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alu_control = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, div_zero, bad_op;
  logic [W-1:0] result, hi;

  int total = 0;
  int passed = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         dz;
    logic         bad;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .alu_control(alu_control),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result(result),
    .hi(hi),
    .zero(zero),
    .div_zero(div_zero),
    .bad_op(bad_op)
  );

  function automatic exp_t model(input logic [3:0] c,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    logic [2*W-1:0] p;
    exp_t e;
    e = '0;
    case (c)
      MOVI: e.res = y;
      MOV:  e.res = x;
      ADD:  e.res = x + y;
      SUB:  e.res = x - y;
      MULT: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
      end
      DIV: begin
        if (y == '0) begin
          e.res = '1;
          e.hi  = x;
          e.dz  = 1'b1;
        end else begin
          e.res = x / y;
          e.hi  = x % y;
        end
      end
      default: e.bad = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    exp_t o;
    if (rst_n && done) begin
      o = {result, hi, zero, div_zero, bad_op};
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_done: got result=%h hi=%h, want no done",
                 result, hi);
      end else begin
        e = sb.pop_front();
        if (o !== e) begin
          $display("FAIL sb_result: got %h/%h z%b dz%b bad%b want %h/%h z%b dz%b bad%b",
                   o.res, o.hi, o.z, o.dz, o.bad, e.res, e.hi, e.z, e.dz, e.bad);
        end else begin
          passed++;
        end
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit push);
    @(negedge clk);
    alu_control = c;
    a = x;
    b = y;
    start = 1'b1;
    if (push) sb.push_back(model(c, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input int max, input int poke,
                           output int n, output int bn, output int ov);
    n = 0;
    bn = 0;
    ov = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (busy) bn++;
      if (busy && done) ov++;
      if (n == poke) begin
        alu_control = ADD;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end while (!done && n < max);
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [2*W+4:0] obs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obs = {busy, done, result, hi, zero, div_zero, bad_op};
    total++;
    if (obs !== '0) $display("FAIL reset_state: got %h want 0", obs);
    else passed++;
  endtask

  task automatic test_single;
    logic [3:0]   codes[3];
    logic [W-1:0] xs[3];
    logic [W-1:0] ys[3];
    int n, bn, ov;
    codes = '{ADD, SUB, SUB};
    xs = '{32'd5, 32'd5, 32'd3};
    ys = '{32'd3, 32'd5, 32'd5};
    for (int i = 0; i < 3; i++) begin
      issue(codes[i], xs[i], ys[i], 1'b1);
      wait_done(5, 0, n, bn, ov);
      total++;
      if (n !== 1 || bn !== 0)
        $display("FAIL single_latency[%0d]: got lat=%0d busy=%0d want 1/0", i, n, bn);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    alu_control = MOVI;
    a = $urandom;
    b = 32'h0000_1234;
    start = 1'b1;
    sb.push_back(model(MOVI, a, b));
    @(posedge clk);
    #1;
    alu_control = MOV;
    a = 32'hDEAD_BEEF;
    b = $urandom;
    sb.push_back(model(MOV, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", done);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult;
    int n, bn, ov;
    issue(MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    wait_done(40, 10, n, bn, ov);
    total++;
    if (n !== 33) $display("FAIL mult_latency: got %0d want 33", n);
    else passed++;
    total++;
    if (bn !== 32) $display("FAIL mult_busy_cycles: got %0d want 32", bn);
    else passed++;
    total++;
    if (ov !== 0) $display("FAIL mult_done_with_busy: got %0d want 0", ov);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) $display("FAIL mult_done_width: got %b want 0", done);
    else passed++;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_bad_op;
    int n, bn, ov;
    issue(4'b1111, $urandom, $urandom, 1'b1);
    wait_done(5, 0, n, bn, ov);
    total++;
    if (n !== 1 || bn !== 0)
      $display("FAIL bad_op_latency: got lat=%0d busy=%0d want 1/0", n, bn);
    else passed++;
  endtask

  task automatic test_div;
    int n, bn, ov;
    issue(DIV, 32'd100, 32'd7, 1'b1);
    wait_done(40, 0, n, bn, ov);
    total++;
    if (n !== 33 || bn !== 32)
      $display("FAIL div_latency: got lat=%0d busy=%0d want 33/32", n, bn);
    else passed++;
    issue(DIV, 32'd9, 32'd0, 1'b1);
    wait_done(5, 0, n, bn, ov);
    total++;
    if (n !== 1 || bn !== 0)
      $display("FAIL div0_latency: got lat=%0d busy=%0d want 1/0", n, bn);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int n, bn, ov, cnt;
    issue(MULT, 32'h1234_5678, 32'h0000_0009, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || result !== '0 || hi !== '0)
      $display("FAIL abort_outputs: got busy=%b result=%h hi=%h want 0/0/0",
               busy, result, hi);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    total++;
    if (cnt !== 0) $display("FAIL abort_no_done: got %0d dones want 0", cnt);
    else passed++;
    issue(ADD, 32'd1, 32'd1, 1'b1);
    wait_done(5, 0, n, bn, ov);
    total++;
    if (n !== 1) $display("FAIL post_abort_add_latency: got %0d want 1", n);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (sb.size() !== 0) $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mult();
    test_bad_op();
    test_div();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution unit on the consuming end of the 4-bit `alu_control` bus produced by the ALU control decoder. It latches two 32-bit operands and one operation code on a `start` handshake. Single-cycle ops (MOVI, ADD, SUB, MOV) complete in one cycle; MULT and DIV run as iterative 32-step sequential operations. It returns the result with a one-cycle `done` pulse and status flags to the register-bank writeback path.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals WIDTH.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request, sampled only in IDLE.
- `alu_control` input 4: operation code, latched with `start`.
- `a` input WIDTH: operand A (rs), latched with `start`.
- `b` input WIDTH: operand B (rt/immediate), latched with `start`.
- `busy` output 1: high while MULT/DIV iterates.
- `done` output 1: one-cycle pulse when `result`/`hi`/flags are valid.
- `result` output WIDTH: main result (low product for MULT, quotient for DIV).
- `hi` output WIDTH: MULT upper product, DIV remainder, 0 otherwise.
- `zero` output 1: `result == 0`, updated with `done`.
- `div_zero` output 1: DIV with `b == 0`, updated with `done`.
- `bad_op` output 1: undefined code, updated with `done`.

## Operation
- Codes: 0000 MOVI (result = b), 0010 ADD (a+b), 0110 SUB (a−b), 0011 MULT (unsigned a×b), 0100 DIV (unsigned a/b), 0001 MOV (result = a). Any other code is undefined.
- ADD/SUB wrap modulo 2^WIDTH. No carry or overflow output.
- FSM states are IDLE, MUL and DIV.
  - IDLE + `start` with a single-cycle or undefined code: compute, register outputs, pulse `done`, stay in IDLE.
  - IDLE + `start` with MULT: load multiplicand, multiplier and a 2·WIDTH accumulator, clear the counter, go to MUL. Each cycle is one shift-add step, LSB first.
  - IDLE + `start` with DIV and b≠0: load the dividend and a zero remainder, go to DIV. Each cycle is one restoring shift-subtract step, MSB first.
  - DIV with b=0: no iteration. result = all ones, hi = a, `div_zero`=1, `done` next cycle, stay in IDLE.
  - MUL/DIV: after iteration WIDTH−1 completes, register `result`/`hi`/flags, pulse `done`, return to IDLE.
- Undefined code: result = 0, hi = 0, `bad_op`=1, `zero`=1.
- `start` while `busy` is ignored; the latched operands and code are unaffected. Operand inputs may change freely after the start cycle.
- `result`, `hi` and flags hold their last values until the next `done`.
- `zero` reflects `result` only, never `hi`.

## Timing
- Reset (async assert, sync release) state: IDLE, busy=0, done=0, result=0, hi=0, zero=0, div_zero=0, bad_op=0, counter=0.
- `start` sampled at edge T.
  - Single-cycle, undefined and DIV-by-zero ops: outputs and `done` valid after edge T+1, `busy` never high.
  - MULT/DIV: `busy` high from after edge T+1 through the edge at which `done` rises. `done` is valid after edge T+WIDTH+1 (T+33 for WIDTH=32), and `busy` is low in that same cycle.
- `start` in the `done` cycle (FSM is in IDLE) is accepted. Back-to-back single-cycle ops give one result per cycle.
- `rst_n` low mid-iteration aborts immediately: outputs go to reset values and no `done` is produced.
- `done` is exactly one cycle wide and is never asserted together with `busy`.

## Test plan
- Reset, then ADD a=0x00000005 b=0x00000003 -> done at T+1, result=0x00000008, zero=0. Then SUB 5−5 -> result=0, zero=1. Then SUB 3−5 -> 0xFFFFFFFE.
- MOVI b=0x1234 then MOV a=0xDEADBEEF, started on consecutive cycles -> two consecutive `done` pulses with 0x00001234 then 0xDEADBEEF.
- MULT a=0xFFFFFFFF b=0x00000002 -> busy 32 cycles, done at T+33, result=0xFFFFFFFE, hi=0x00000001. A `start` pulsed mid-run is ignored.
- DIV a=100 b=7 -> done at T+33, result=14, hi=2. Then DIV a=9 b=0 -> done at T+1, result=0xFFFFFFFF, hi=9, div_zero=1.
- Code 1111 -> done at T+1, result=0, bad_op=1, zero=1.
- Start MULT, drop `rst_n` at T+10 -> busy=0, result=0, and no `done` within 40 cycles. After reset is released, ADD 1+1 returns 2.
